tu_trigger_tx: RTL and testbench
================================

Name: tu_trigger_tx

Overview:
- Transmit-side counterpart of the trigger-unit bitslip aligner. Drives a 64-bit parallel word per S_AXI_ACLK into 8 OSERDES lanes, 8 bits per lane, emulating VFAT3 trigger output for loopback and testbench use.
- Emits a training sequence whose word changes every cycle, so the far-end aligner can bitslip until lock.
- After training, streams payload words from a small internal FIFO; when the FIFO is empty it sends IDLE_WORD.
- Applies the inverse of the receiver's lane/bit transpose, so the receiver recovers each payload word unchanged.

Parameters:
- TRAIN_LEN, 16384, number of training frames sent per training request; must exceed the worst-case aligner search time.
- FIFO_DEPTH, 4, payload FIFO depth in words; power of 2, minimum 2.
- IDLE_WORD, 64'h0, logical word sent when there is nothing to transmit.

Ports:
- S_AXI_ACLK  in  1  single clock; all logic on its rising edge.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- train_start  in  1  training request; acted on at its rising edge.
- data_en  in  1  level; enables payload streaming.
- din  in  64  logical payload word.
- din_valid  in  1  din holds a valid word.
- din_ready  out  1  FIFO can accept a word.
- tx_data  out  64  registered word to the OSERDES lanes; lane l is tx_data[8l+7:8l].
- tx_busy  out  1  high in TRAIN or DATA.
- train_done  out  1  one-cycle pulse on the last training frame.
- frame_cnt  out  16  payload words sent, saturating at 16'hFFFF.

Behaviour:
- Reset values:
  - Registered: tx_data = transposed IDLE_WORD, train_done = 0, frame_cnt = 0, FIFO emptied, state = IDLE, train counter = 0, train_start_p = 0.
  - Combinational, therefore 1 during reset: din_ready.
  - Combinational, therefore 0 during reset: tx_busy.
  - Reset mid-TRAIN or mid-DATA takes effect on the next edge; FIFO contents are discarded.
- Transpose: for logical word w, tx_data[8l+b] = w[8b+7-l], with l = lane 0..7 and b = bit 0..7. Examples: w[63] goes to tx_data[7]; w[0] goes to tx_data[56].
- Edge detect: train_start_p is a 1-cycle delayed copy of train_start. The edge is train_start & ~train_start_p.
- State IDLE:
  - tx_data = transposed IDLE_WORD.
  - Rising edge of train_start: go to TRAIN and clear the train counter.
  - Otherwise, data_en = 1: go to DATA.
  - If both occur in the same cycle, TRAIN wins.
- State TRAIN:
  - Each cycle, with c = train counter[7:0], the logical word has byte k = (c + k) mod 256, for k = 0..7. Consecutive words therefore always differ.
  - The counter increments each cycle.
  - When counter = TRAIN_LEN-1: send that frame, pulse train_done in the same cycle, and return to IDLE on the next edge.
  - train_start edges during TRAIN are ignored.
  - The FIFO still accepts writes while in TRAIN.
- State DATA:
  - FIFO non-empty: pop the head, send it (transposed), and increment frame_cnt unless it is already at FFFF.
  - FIFO empty: send IDLE_WORD.
  - Return to IDLE only when data_en = 0 and the FIFO is empty. With data_en = 0 and the FIFO non-empty, keep draining.
  - A train_start edge in DATA is ignored.
- Outputs: tx_busy = (state is TRAIN or DATA), combinational from state.
- FIFO:
  - din_ready = ~full, combinational.
  - A write occurs when din_valid & din_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A full FIFO cannot push, even if a pop occurs that cycle.
  - Overflow and underflow are impossible by construction.
- Latency: a word accepted on edge n, into an empty FIFO while in DATA, appears on tx_data after edge n+1. Words leave in acceptance order.

Test Plan:
- Reset, then hold S_AXI_ARESET = 0 with no stimulus -> tx_data = 0, din_ready = 1, tx_busy = 0, frame_cnt = 0.
- TRAIN_LEN = 8, pulse train_start -> 8 frames with logical bytes {c+7..c} for c = 0..7:
  - 1st frame has logical word 64'h0706050403020100.
  - train_done is high exactly on the 8th frame, then the block returns to IDLE.
  - A loopback through a behavioural transpose model recovers each word.
- data_en = 1, write 64'h8000000000000001 -> tx_data[7] = 1 and tx_data[56] = 1, all other bits 0, one cycle after acceptance; frame_cnt = 1.
- Fill the FIFO with 4 words while in IDLE -> din_ready = 0 after the 4th write. Then set data_en = 1 -> the 4 words are sent in order on consecutive cycles, din_ready goes high again, and IDLE_WORD follows.
- data_en = 1 and a train_start edge in the same IDLE cycle -> TRAIN entered; after train_done the block enters DATA.
- Assert reset during DATA with 3 words queued -> all outputs return to reset values next edge, the queued words are never sent, and frame_cnt = 0.

Source files
------------

// File: rtl/tu_trigger_tx.sv
// Trigger-unit transmitter: sends training frames, then payload words from a small FIFO,
// pre-transposed so the bitslip aligner on the far end recovers each logical word.
module tu_trigger_tx #(
    parameter int          TRAIN_LEN  = 16384,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [63:0] IDLE_WORD  = 64'h0
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESET,
    input  logic        train_start,
    input  logic        data_en,
    input  logic [63:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [63:0] tx_data,
    output logic        tx_busy,
    output logic        train_done,
    output logic [15:0] frame_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = ($clog2(TRAIN_LEN) > 8) ? $clog2(TRAIN_LEN) : 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAIN,
        ST_DATA
    } state_t;

    // Lane l carries logical bit 8b+7-l in its bit position b; inverse of the receiver's transpose.
    function automatic logic [63:0] transpose(input logic [63:0] w);
        logic [63:0] t;
        for (int l = 0; l < 8; l++) begin
            for (int b = 0; b < 8; b++) begin
                t[8*l + b] = w[8*b + 7 - l];
            end
        end
        return t;
    endfunction

    function automatic logic [63:0] train_word(input logic [7:0] c);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) begin
            w[8*k +: 8] = c + 8'(k);
        end
        return w;
    endfunction

    state_t           state_q;
    logic [CNT_W-1:0] train_cnt_q;
    logic             train_start_p_q;
    logic [63:0]      tx_data_q;
    logic             train_done_q;
    logic [15:0]      frame_cnt_q;

    logic [63:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;

    logic fifo_full, fifo_empty, push, pop, train_edge, train_last;
    logic [63:0] fifo_head;

    assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = mem_q[rd_ptr_q];
    assign push       = din_valid & ~fifo_full;
    assign pop        = (state_q == ST_DATA) & ~fifo_empty;
    assign train_edge = train_start & ~train_start_p_q;
    assign train_last = (train_cnt_q == CNT_W'(TRAIN_LEN - 1));

    assign din_ready  = ~fifo_full;
    assign tx_busy    = (state_q != ST_IDLE);
    assign tx_data    = tx_data_q;
    assign train_done = train_done_q;
    assign frame_cnt  = frame_cnt_q;

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage has no reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge S_AXI_ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (S_AXI_ARESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q         <= ST_IDLE;
            train_cnt_q     <= '0;
            train_start_p_q <= 1'b0;
            tx_data_q       <= transpose(IDLE_WORD);
            train_done_q    <= 1'b0;
            frame_cnt_q     <= '0;
        end else begin
            train_start_p_q <= train_start;
            train_done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_data_q <= transpose(IDLE_WORD);
                    if (train_edge) begin
                        state_q     <= ST_TRAIN;
                        train_cnt_q <= '0;
                    end else if (data_en) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_TRAIN: begin
                    tx_data_q   <= transpose(train_word(train_cnt_q[7:0]));
                    train_cnt_q <= train_cnt_q + CNT_W'(1);
                    if (train_last) begin
                        train_done_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (!fifo_empty) begin
                        tx_data_q <= transpose(fifo_head);
                        if (frame_cnt_q != 16'hFFFF) begin
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end
                    end else begin
                        tx_data_q <= transpose(IDLE_WORD);
                    end
                    // Keep draining after data_en drops; leave only once nothing is queued.
                    if (!data_en && fifo_empty) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tu_trigger_tx.sv
// Directed bench for tu_trigger_tx with a queue-based reference model checked every cycle.
module tb_tu_trigger_tx;

    localparam int          TL    = 8;
    localparam int          DEPTH = 4;
    localparam logic [63:0] IDLE  = 64'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        train_start, data_en, din_valid;
    logic [63:0] din;
    logic        din_ready, tx_busy, train_done;
    logic [63:0] tx_data;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tu_trigger_tx #(
        .TRAIN_LEN (TL),
        .FIFO_DEPTH(DEPTH),
        .IDLE_WORD (IDLE)
    ) dut (
        .S_AXI_ACLK  (clk),
        .S_AXI_ARESET(rst),
        .train_start (train_start),
        .data_en     (data_en),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .train_done  (train_done),
        .frame_cnt   (frame_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Receiver-side view: logical bit i sits in lane 7-(i%8), bit position i/8.
    function automatic logic [63:0] untranspose(input logic [63:0] t);
        logic [63:0] w;
        for (int i = 0; i < 64; i++) w[i] = t[8 * (7 - (i % 8)) + i / 8];
        return w;
    endfunction

    function automatic logic [63:0] train_logical(input int c);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'((c + k) % 256);
        return w;
    endfunction

    // Reference model: mode 0 idle, 1 training, 2 streaming.
    logic [63:0] m_q[$];
    int          m_mode = 0;
    int          m_tcnt = 0;
    int          m_fcnt = 0;
    logic        m_prev = 1'b0;
    logic [63:0] m_word = IDLE;
    logic        m_done = 1'b0;
    bit          m_on   = 1'b0;

    task automatic model_step();
        int  sz;
        logic rise;
        if (rst) begin
            m_q.delete();
            m_mode = 0; m_tcnt = 0; m_fcnt = 0;
            m_prev = 1'b0; m_word = IDLE; m_done = 1'b0; m_on = 1'b1;
            return;
        end
        if (!m_on) return;
        sz     = m_q.size();
        rise   = train_start && !m_prev;
        m_prev = train_start;
        m_done = 1'b0;
        case (m_mode)
            0: begin
                m_word = IDLE;
                if (rise) begin m_mode = 1; m_tcnt = 0; end
                else if (data_en) m_mode = 2;
            end
            1: begin
                m_word = train_logical(m_tcnt);
                if (m_tcnt == TL - 1) begin m_done = 1'b1; m_mode = 0; end
                else m_tcnt++;
            end
            default: begin
                if (sz > 0) begin
                    m_word = m_q.pop_front();
                    if (m_fcnt < 65535) m_fcnt++;
                end else begin
                    m_word = IDLE;
                end
                if (!data_en && sz == 0) m_mode = 0;
            end
        endcase
        if (din_valid && sz < DEPTH) m_q.push_back(din);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (m_on) begin
                check("tx_data", untranspose(tx_data), m_word);
                check("train_done", 64'(train_done), 64'(m_done));
                check("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
                check("din_ready", 64'(din_ready), 64'(m_q.size() < DEPTH));
                check("tx_busy", 64'(tx_busy), 64'(m_mode != 0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts frames from the one just sampled until train_done, bounded.
    task automatic wait_train(input string name, input int first_frames);
        int          frames;
        int          done_at;
        logic [63:0] last;
        frames  = first_frames;
        done_at = (train_done === 1'b1) ? frames : 0;
        last    = untranspose(tx_data);
        while (done_at == 0 && frames < 20) begin
            step();
            frames++;
            if (train_done === 1'b1) begin
                done_at = frames;
                last    = untranspose(tx_data);
            end
        end
        check({name, " done_frame"}, 64'(done_at), 64'(TL));
        check({name, " last_frame"}, last, 64'h0E0D0C0B0A090807);
        check({name, " busy_at_done"}, 64'(tx_busy), 64'(0));
    endtask

    logic [63:0] words [4];

    initial begin
        words[0] = 64'h1111_2222_3333_4444;
        words[1] = 64'hDEAD_BEEF_0123_4567;
        words[2] = 64'hA5A5_5A5A_F00F_0FF0;
        words[3] = 64'h0000_0000_0000_00FF;
        rst = 1'b1; train_start = 1'b0; data_en = 1'b0; din_valid = 1'b0; din = '0;

        // Reset, then quiet idle.
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst tx_data", tx_data, 64'h0);
        check("rst din_ready", 64'(din_ready), 64'(1));
        check("rst tx_busy", 64'(tx_busy), 64'(0));
        check("rst frame_cnt", 64'(frame_cnt), 64'(0));

        // Training burst.
        @(negedge clk) train_start = 1'b1;
        step();
        @(negedge clk) train_start = 1'b0;
        step();
        check("train frame0", untranspose(tx_data), 64'h0706050403020100);
        wait_train("train1", 1);

        // Single payload word: lands on lanes 0 bit 7 and lane 7 bit 0.
        @(negedge clk) data_en = 1'b1;
        @(negedge clk) begin din = 64'h8000_0000_0000_0001; din_valid = 1'b1; end
        step();
        @(negedge clk) din_valid = 1'b0;
        step();
        check("single tx_data", tx_data, 64'h0100_0000_0000_0080);
        check("single frame_cnt", 64'(frame_cnt), 64'(1));
        @(negedge clk) data_en = 1'b0;
        step();
        check("single back_idle", 64'(tx_busy), 64'(0));

        // Fill the FIFO while idle, then stream it out.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) begin din = words[i]; din_valid = 1'b1; end
        end
        @(negedge clk) din_valid = 1'b0;
        check("fill din_ready", 64'(din_ready), 64'(0));
        data_en = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check("burst word", untranspose(tx_data), words[i]);
            if (i == 0) check("burst din_ready", 64'(din_ready), 64'(1));
        end
        step();
        check("burst idle_after", tx_data, 64'h0);
        check("burst frame_cnt", 64'(frame_cnt), 64'(5));

        // Training request and data_en together in idle: training wins, data follows.
        @(negedge clk) data_en = 1'b0;
        step();
        check("both pre_idle", 64'(tx_busy), 64'(0));
        @(negedge clk) begin train_start = 1'b1; data_en = 1'b1; end
        step();
        check("both busy", 64'(tx_busy), 64'(1));
        @(negedge clk) train_start = 1'b0;
        step();
        check("both frame0", untranspose(tx_data), 64'h0706050403020100);
        wait_train("train2", 1);
        step();
        check("both data_after", 64'(tx_busy), 64'(1));

        // Reset in streaming with three words queued.
        @(negedge clk) data_en = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) begin din = words[i]; din_valid = 1'b1; end
        end
        @(negedge clk) begin din_valid = 1'b0; data_en = 1'b1; end
        step();
        check("pre_rst busy", 64'(tx_busy), 64'(1));
        @(negedge clk) rst = 1'b1;
        step();
        check("mid_rst tx_data", tx_data, 64'h0);
        check("mid_rst frame_cnt", 64'(frame_cnt), 64'(0));
        check("mid_rst tx_busy", 64'(tx_busy), 64'(0));
        check("mid_rst din_ready", 64'(din_ready), 64'(1));
        @(negedge clk) rst = 1'b0;
        repeat (6) begin
            step();
            check("post_rst tx_data", tx_data, 64'h0);
        end
        check("post_rst frame_cnt", 64'(frame_cnt), 64'(0));

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
